// File: rtl/gpio_pinmux_pkg.sv
// gpio_pinmux_pkg
// Shared types and constants for the GPIO pad multiplexer.
//   pin_state_t  : per-pin FSM state (ACTIVE drives the selected source,
//                  GUARD holds the pad tristated after a re-select)
//   STATUS_ADDR  : read-only status register (bit0 = any pin in GUARD)
//   LOCK_ADDR    : sticky lock register (bit0)
//   GUARD_CNT_W  : width of the per-pin guard counter
package gpio_pinmux_pkg;

  typedef enum logic {
    ACTIVE = 1'b0,
    GUARD  = 1'b1
  } pin_state_t;

  localparam logic [5:0] STATUS_ADDR = 6'd62;
  localparam logic [5:0] LOCK_ADDR   = 6'd63;
  localparam int         GUARD_CNT_W = 4;

endpackage

// File: rtl/gpio_pin_slot.sv
// gpio_pin_slot
// One pad of the pinmux: select register, ACTIVE/GUARD FSM with guard
// counter, and the registered pad output enable / data.
//   clk, nrst    : clock, asynchronous active-low reset
//   i_wr         : write strobe for this pin's select (already lock-qualified)
//   i_wdata      : new select value
//   i_src_oeb    : output enable of every source for this pad (active-low)
//   i_src_out    : output data of every source for this pad
//   o_sel        : current select value
//   o_oeb, o_out : registered pad output enable / data
//   o_guard      : high while the pad is held safe after a re-select
module gpio_pin_slot
  import gpio_pinmux_pkg::*;
#(
  parameter int NUM_SRC      = 13,
  parameter int SEL_W        = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_wr,
  input  logic [SEL_W-1:0]   i_wdata,
  input  logic [NUM_SRC-1:0] i_src_oeb,
  input  logic [NUM_SRC-1:0] i_src_out,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_oeb,
  output logic               o_out,
  output logic               o_guard
);

  localparam int                     EXT_W      = 2 ** SEL_W;
  localparam logic [GUARD_CNT_W-1:0] GUARD_LOAD = GUARD_CNT_W'(GUARD_CYCLES - 1);

  pin_state_t             r_state;
  logic [SEL_W-1:0]       r_sel;
  logic [GUARD_CNT_W-1:0] r_cnt;
  logic                   r_oeb;
  logic                   r_out;

  // Pad the source vectors to the full select range with the safe value
  // (oeb=1, out=0), so any select >= NUM_SRC naturally picks a tristate.
  logic [EXT_W-1:0] w_oeb_ext;
  logic [EXT_W-1:0] w_out_ext;
  logic             w_reselect;

  assign w_oeb_ext  = {{(EXT_W - NUM_SRC){1'b1}}, i_src_oeb};
  assign w_out_ext  = {{(EXT_W - NUM_SRC){1'b0}}, i_src_out};
  assign w_reselect = i_wr && (i_wdata != r_sel);

  // The counter is loaded with GUARD_CYCLES-1 on the write edge, so the
  // safe value is held for exactly GUARD_CYCLES edges (write edge included)
  // and the new source lands on the edge where the count has reached zero.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; every register has an async reset value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ACTIVE;
      r_sel   <= '1;
      r_cnt   <= '0;
      r_oeb   <= 1'b1;
      r_out   <= 1'b0;
    end else if (w_reselect) begin
      // A differing write always (re)starts the full guard, even mid-guard.
      r_sel   <= i_wdata;
      r_state <= GUARD;
      r_cnt   <= GUARD_LOAD;
      r_oeb   <= 1'b1;
      r_out   <= 1'b0;
    end else begin
      case (r_state)
        ACTIVE: begin
          r_oeb <= w_oeb_ext[r_sel];
          r_out <= w_out_ext[r_sel];
        end
        GUARD: begin
          if (r_cnt == '0) begin
            r_state <= ACTIVE;
            r_oeb   <= w_oeb_ext[r_sel];
            r_out   <= w_out_ext[r_sel];
          end else begin
            r_cnt <= r_cnt - 1'b1;
            r_oeb <= 1'b1;
            r_out <= 1'b0;
          end
        end
        default: r_state <= ACTIVE;
      endcase
    end
  end

  assign o_sel   = r_sel;
  assign o_oeb   = r_oeb;
  assign o_out   = r_out;
  assign o_guard = (r_state == GUARD);

endmodule

// File: rtl/gpio_pinmux_ctrl.sv
// gpio_pinmux_ctrl
// Multiplexes NUM_SRC source designs onto NUM_PINS pads, one select
// register per pad, with a tristate guard on every re-select and a sticky
// lock that freezes the selects.
//   clk, nrst               : clock, asynchronous active-low reset
//   io_oeb, io_out          : per-source pad enables (active-low) / data
//   wr_en, addr, wdata      : register write port
//   rdata                   : read data, one cycle after addr
//   muxxed_io_oeb/out       : registered pad enables / data
//   guard_active            : per-pad guard indicator
// Register map: 0..NUM_PINS-1 pin select, STATUS_ADDR (bit0 = any guard),
// LOCK_ADDR (bit0, sticky). Everything else reads 0, writes ignored.
module gpio_pinmux_ctrl
  import gpio_pinmux_pkg::*;
#(
  parameter int NUM_PINS     = 38,
  parameter int NUM_SRC      = 13,
  parameter int SEL_W        = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic [NUM_SRC-1:0][NUM_PINS-1:0]  io_oeb,
  input  logic [NUM_SRC-1:0][NUM_PINS-1:0]  io_out,
  input  logic                              wr_en,
  input  logic [5:0]                        addr,
  input  logic [SEL_W-1:0]                  wdata,
  output logic [SEL_W-1:0]                  rdata,
  output logic [NUM_PINS-1:0]               muxxed_io_oeb,
  output logic [NUM_PINS-1:0]               muxxed_io_out,
  output logic [NUM_PINS-1:0]               guard_active
);

  localparam logic [6:0] NUM_PINS_W = 7'(NUM_PINS);

  logic [SEL_W-1:0] w_sel [NUM_PINS];
  logic             r_lock;
  logic [SEL_W-1:0] r_rdata;
  logic [SEL_W-1:0] w_rd;

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    logic [NUM_SRC-1:0] w_col_oeb;
    logic [NUM_SRC-1:0] w_col_out;
    logic               w_wr;

    // Gather this pad's bit from every source.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      assign w_col_oeb[s] = io_oeb[s][p];
      assign w_col_out[s] = io_out[s][p];
    end

    assign w_wr = wr_en && !r_lock && (addr == 6'(p));

    gpio_pin_slot #(
      .NUM_SRC      (NUM_SRC),
      .SEL_W        (SEL_W),
      .GUARD_CYCLES (GUARD_CYCLES)
    ) u_slot (
      .clk       (clk),
      .nrst      (nrst),
      .i_wr      (w_wr),
      .i_wdata   (wdata),
      .i_src_oeb (w_col_oeb),
      .i_src_out (w_col_out),
      .o_sel     (w_sel[p]),
      .o_oeb     (muxxed_io_oeb[p]),
      .o_out     (muxxed_io_out[p]),
      .o_guard   (guard_active[p])
    );
  end

  // NOTE: every variable assigned in always_comb gets a default first so no
  // latch is inferred on paths that do not assign it.
  always_comb begin
    w_rd = '0;
    if ({1'b0, addr} < NUM_PINS_W) begin
      w_rd = w_sel[addr];
    end else if (addr == STATUS_ADDR) begin
      w_rd[0] = |guard_active;
    end else if (addr == LOCK_ADDR) begin
      w_rd[0] = r_lock;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_lock  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rd;
      if (wr_en && (addr == LOCK_ADDR) && wdata[0]) begin
        r_lock <= 1'b1;
      end
    end
  end

  assign rdata = r_rdata;

endmodule

// File: doc/gpio_pinmux_ctrl.md
GPIO_PINMUX_CTRL -- requirements
Module: gpio_pinmux_ctrl

Interface
REQ-001 SHALL have parameter NUM_PINS, default 38, meaning the number of pads muxed.
REQ-002 SHALL have parameter NUM_SRC, default 13, meaning the number of source designs.
REQ-003 SHALL have parameter SEL_W, default 4, meaning the select width; NUM_SRC <= 2**SEL_W - 1.
REQ-004 SHALL have parameter GUARD_CYCLES, default 2, meaning the tristate guard length on re-select; legal range is 1..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port io_oeb, input, [NUM_SRC-1:0][NUM_PINS-1:0]: per-design output enables, active-low.
REQ-008 SHALL have port io_out, input, [NUM_SRC-1:0][NUM_PINS-1:0]: per-design output data.
REQ-009 SHALL have port wr_en, input, 1 bit: register write strobe.
REQ-010 SHALL have port addr, input, 6 bits: register address.
REQ-011 SHALL have port wdata, input, SEL_W bits: write data.
REQ-012 SHALL have port rdata, output, SEL_W bits: registered read data.
REQ-013 SHALL have port muxxed_io_oeb, output, NUM_PINS bits: registered pad output enables.
REQ-014 SHALL have port muxxed_io_out, output, NUM_PINS bits: registered pad output data.
REQ-015 SHALL have port guard_active, output, NUM_PINS bits: per-pin high while the pin is in GUARD.

Function
REQ-016 Register map SHALL be: addr 0..NUM_PINS-1 = pin select; addr 62 = STATUS (read-only, bit0 = OR of guard_active); addr 63 = LOCK (bit0).
REQ-017 Writes to unmapped addresses or to STATUS SHALL be ignored; reads of them SHALL return 0.
REQ-018 rdata SHALL show the register at the addr sampled on the previous edge (1-cycle read latency).
REQ-019 Writing LOCK with bit0=1 SHALL set lock; lock is sticky and clears only on reset.
REQ-020 While lock=1, writes to select registers SHALL be ignored, and no guard SHALL be started.
REQ-021 Each pin SHALL run an FSM with states ACTIVE and GUARD.
REQ-022 ACTIVE with sel < NUM_SRC: each edge, muxxed_io_oeb[p] <= io_oeb[sel][p] and muxxed_io_out[p] <= io_out[sel][p] (1-cycle latency).
REQ-023 ACTIVE with sel >= NUM_SRC: the pin SHALL output the safe value, oeb=1 and out=0.
REQ-024 A write at edge E0 whose value differs from the current sel SHALL update sel and enter GUARD.
REQ-025 In GUARD, outputs SHALL take the safe value at edges E0..E0+GUARD_CYCLES-1.
REQ-026 The new source SHALL first appear at edge E0+GUARD_CYCLES; guard_active is high over the same window.
REQ-027 A write equal to the current sel SHALL cause no guard and no output disturbance.
REQ-028 A differing write while in GUARD SHALL update sel and restart the full guard count.
REQ-029 Pins SHALL be independent; a write to one pin SHALL never disturb another.
REQ-030 Guard counter width SHALL be 4 bits; the counter SHALL never wrap.

Reset
REQ-031 On nrst low, asynchronously: all sel = {SEL_W{1'b1}} (tristate), all FSMs = ACTIVE, lock = 0, rdata = 0, muxxed_io_oeb = all 1, muxxed_io_out = all 0, guard_active = 0.
REQ-032 Reset asserted mid-guard SHALL abort the guard immediately; no source SHALL be driven until it is written after reset.

Structure
REQ-033 Package gpio_pinmux_pkg SHALL hold the pin_state_t enum (ACTIVE, GUARD) and the STATUS_ADDR=62 and LOCK_ADDR=63 constants.
REQ-034 Sub-module gpio_pin_slot SHALL hold the per-pin select register, guard FSM/counter and output registers, instantiated NUM_PINS times via generate.

Verification
REQ-035 Reset then read addr 5 -> rdata=4'hF; all muxxed_io_oeb=1, all muxxed_io_out=0.
REQ-036 Write pin 3 sel=2 with io_out[2][3]=1, io_oeb[2][3]=0 -> pin 3 safe for 2 edges, guard_active[3]=1 for those 2 edges, then out=1, oeb=0.
REQ-037 Write pin 3 sel=2, then sel=7 one edge later -> guard restarts; source 7 appears 2 edges after the second write.
REQ-038 Write pin 3 with its current value 2 -> no guard; outputs unchanged.
REQ-039 Write LOCK=1, then pin 0 sel=1 -> read pin 0 = 4'hF, pin stays safe, read LOCK = 1.
REQ-040 Write pin 10 sel=12, then write sel=13 (>= NUM_SRC) -> safe output after the guard; assert nrst mid-guard -> immediate safe outputs and all sel = 4'hF.
